// File: rtl/wb_regfile_pkg.sv
// Pipeline-wide constants shared by decode, forwarding and write-back.
package wb_regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  // Architectural zero register index: never written, always reads zero.
  localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read/one-write architectural register file with synchronous clear,
// hardwired zero register and same-cycle write-to-read bypass.
module regfile_2r1w #(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              commit
);
  import wb_regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  // A write only lands when enabled, not aimed at r0, and not swallowed by reset;
  // the same qualifier gates the bypass so reset also suppresses forwarding.
  assign commit = we && (waddr != ZERO_IDX) && !rst;

  // Next array contents: unchanged except the committed destination.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      regs_d[waddr] = wdata;
    end
  end

  // Array storage with synchronous clear; entry 0 is only ever cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: zero register first, then bypass of the in-flight write, then array.
  assign rdata1 = (raddr1 == ZERO_IDX)            ? '0    :
                  (commit && (raddr1 == waddr))   ? wdata :
                                                    regs_q[raddr1];

  assign rdata2 = (raddr2 == ZERO_IDX)            ? '0    :
                  (commit && (raddr2 == waddr))   ? wdata :
                                                    regs_q[raddr2];

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: selects load data or ALU result, commits it into the
// register file and counts committed register writes.
module wb_regfile #(
  parameter int DATA_W   = wb_regfile_pkg::DATA_W,
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS,
  parameter int ADDR_W   = wb_regfile_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  input  logic [DATA_W-1:0] MemData,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic [DATA_W-1:0] WriteData,
  output logic [31:0]       commit_count
);
  import wb_regfile_pkg::*;

  logic        commit;
  logic [31:0] commit_count_q;
  logic [31:0] commit_count_d;

  // Write-back select; independent of reset so EX forwarding always sees it.
  always_comb begin
    WriteData = MemtoReg ? MemData : ALU_result;
  end

  regfile_2r1w #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_rf (
    .clk    (clk),
    .rst    (rst),
    .we     (RegWrite),
    .waddr  (WriteReg),
    .wdata  (WriteData),
    .raddr1 (ReadReg1),
    .raddr2 (ReadReg2),
    .rdata1 (ReadData1),
    .rdata2 (ReadData2),
    .commit (commit)
  );

  // Commit counter next value; wraps silently at 2^32.
  always_comb begin
    commit_count_d = commit_count_q;
    if (commit) begin
      commit_count_d = commit_count_q + 32'd1;
    end
  end

  // Commit counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_count_q <= '0;
    end else begin
      commit_count_q <= commit_count_d;
    end
  end

  assign commit_count = commit_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against a behavioural register-file model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemtoReg;
  logic        RegWrite;
  logic [31:0] MemData;
  logic [31:0] ALU_result;
  logic [4:0]  WriteReg;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic [31:0] WriteData;
  logic [31:0] commit_count;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] mregs [32];
  logic [31:0] mcount;

  wb_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .MemData      (MemData),
    .ALU_result   (ALU_result),
    .WriteReg     (WriteReg),
    .ReadReg1     (ReadReg1),
    .ReadReg2     (ReadReg2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .WriteData    (WriteData),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_wd();
    return MemtoReg ? MemData : ALU_result;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (!rst && RegWrite && WriteReg != 5'd0 && idx == WriteReg) return m_wd();
    return mregs[idx];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      foreach (mregs[i]) mregs[i] = 32'd0;
      mcount = 32'd0;
    end else if (RegWrite && WriteReg != 5'd0) begin
      mregs[WriteReg] = m_wd();
      mcount = mcount + 32'd1;
    end
    #1;
  endtask

  task automatic drive(input logic mtr, input logic rw, input logic [31:0] md,
                       input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] r1, input logic [4:0] r2);
    MemtoReg   = mtr;
    RegWrite   = rw;
    MemData    = md;
    ALU_result = alu;
    WriteReg   = wr;
    ReadReg1   = r1;
    ReadReg2   = r2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    for (int i = 1; i < 32; i++) begin
      drive(1'($urandom), 1'b1, 32'($urandom) | 32'd1, 32'($urandom) | 32'd1, 5'(i), 5'd0, 5'd0);
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd17, 5'd31);
    checks++;
    if (ReadData1 !== mregs[17] || ReadData1 === 32'd0) begin
      errors++;
      $display("FAIL reset_prefill_r17: got %h expected %h", ReadData1, mregs[17]);
    end
    checks++;
    if (commit_count !== 32'd31) begin
      errors++;
      $display("FAIL reset_prefill_count: got %0d expected 31", commit_count);
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(31 - i));
      checks++;
      if (ReadData1 !== 32'd0 || ReadData2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_read r%0d: got %h/%h expected 0/0", i, ReadData1, ReadData2);
      end
    end
    checks++;
    if (commit_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", commit_count);
    end
  endtask

  task automatic test_select();
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd8, 5'd0, 5'd0);
    checks++;
    if (WriteData !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL select_mem: got %h expected deadbeef", WriteData);
    end
    tick();
    drive(1'b0, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd9, 5'd8, 5'd0);
    checks++;
    if (WriteData !== 32'h12345678) begin
      errors++;
      $display("FAIL select_alu: got %h expected 12345678", WriteData);
    end
    checks++;
    if (ReadData1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL select_r8: got %h expected deadbeef", ReadData1);
    end
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd9, 5'd8);
    checks++;
    if (ReadData1 !== 32'h12345678 || ReadData2 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL select_r9_r8: got %h/%h expected 12345678/deadbeef", ReadData1, ReadData2);
    end
    checks++;
    if (commit_count !== 32'd2) begin
      errors++;
      $display("FAIL select_count: got %0d expected 2", commit_count);
    end
  endtask

  task automatic test_zero_reg();
    logic [31:0] c0;
    c0 = mcount;
    drive(1'b0, 1'b1, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ReadData1 !== 32'd0 || WriteData !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL zero_same: got rd=%h wd=%h expected 0/ffffffff", ReadData1, WriteData);
    end
    tick();
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (ReadData1 !== 32'd0) begin
      errors++;
      $display("FAIL zero_next: got %h expected 0", ReadData1);
    end
    checks++;
    if (commit_count !== c0) begin
      errors++;
      $display("FAIL zero_count: got %0d expected %0d", commit_count, c0);
    end
  endtask

  task automatic test_bypass();
    drive(1'b0, 1'b1, 32'd0, 32'h11, 5'd5, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b1, 32'd0, 32'h22, 5'd5, 5'd5, 5'd5);
    checks++;
    if (ReadData1 !== 32'h22 || ReadData2 !== 32'h22) begin
      errors++;
      $display("FAIL bypass_on: got %h/%h expected 22/22", ReadData1, ReadData2);
    end
    drive(1'b0, 1'b0, 32'd0, 32'h22, 5'd5, 5'd5, 5'd5);
    checks++;
    if (ReadData1 !== 32'h11 || ReadData2 !== 32'h11) begin
      errors++;
      $display("FAIL bypass_off: got %h/%h expected 11/11", ReadData1, ReadData2);
    end
    tick();
  endtask

  task automatic test_reset_vs_write();
    drive(1'b0, 1'b1, 32'd0, 32'h55, 5'd3, 5'd0, 5'd0);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'd0, 32'hAA, 5'd3, 5'd3, 5'd3);
    checks++;
    if (ReadData1 !== 32'h55 || ReadData2 !== 32'h55) begin
      errors++;
      $display("FAIL rst_no_bypass: got %h/%h expected 55/55", ReadData1, ReadData2);
    end
    checks++;
    if (WriteData !== 32'hAA) begin
      errors++;
      $display("FAIL rst_writedata: got %h expected aa", WriteData);
    end
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd3, 5'd3);
    checks++;
    if (ReadData1 !== 32'd0) begin
      errors++;
      $display("FAIL rst_r3: got %h expected 0", ReadData1);
    end
    checks++;
    if (commit_count !== 32'd0) begin
      errors++;
      $display("FAIL rst_count: got %0d expected 0", commit_count);
    end
  endtask

  task automatic test_counter();
    int nc = 100;
    int nz = 20;
    int ni = 10;
    int r;
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    while (nc + nz + ni > 0) begin
      r = int'($urandom_range(0, nc + nz + ni - 1));
      if (r < nc) begin
        drive(1'($urandom), 1'b1, 32'($urandom), 32'($urandom), 5'($urandom_range(1, 31)), 5'd0, 5'd0);
        nc--;
      end else if (r < nc + nz) begin
        drive(1'($urandom), 1'b1, 32'($urandom), 32'($urandom), 5'd0, 5'd0, 5'd0);
        nz--;
      end else begin
        drive(1'($urandom), 1'b0, 32'($urandom), 32'($urandom), 5'($urandom), 5'd0, 5'd0);
        ni--;
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (commit_count !== 32'd100) begin
      errors++;
      $display("FAIL counter_100: got %0d expected 100", commit_count);
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'(i), 5'(i));
      checks++;
      if (ReadData1 !== m_read(5'(i)) || ReadData2 !== m_read(5'(i))) begin
        errors++;
        $display("FAIL counter_contents r%0d: got %h/%h expected %h", i, ReadData1, ReadData2, m_read(5'(i)));
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] wr;
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      wr = 5'($urandom);
      drive(1'($urandom), 1'($urandom_range(0, 3) != 0), 32'($urandom), 32'($urandom), wr,
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom),
            ($urandom_range(0, 2) == 0) ? wr : 5'($urandom));
      checks++;
      if (WriteData !== m_wd()) begin
        errors++;
        $display("FAIL rand_wd cyc %0d: got %h expected %h", n, WriteData, m_wd());
      end
      checks++;
      if (ReadData1 !== m_read(ReadReg1) || ReadData2 !== m_read(ReadReg2)) begin
        errors++;
        $display("FAIL rand_read cyc %0d r%0d/r%0d: got %h/%h expected %h/%h", n, ReadReg1, ReadReg2,
                 ReadData1, ReadData2, m_read(ReadReg1), m_read(ReadReg2));
      end
      checks++;
      if (commit_count !== mcount) begin
        errors++;
        $display("FAIL rand_count cyc %0d: got %0d expected %0d", n, commit_count, mcount);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mcount = 32'd0;
    foreach (mregs[i]) mregs[i] = 32'd0;
    test_reset();
    test_select();
    test_zero_reg();
    test_bypass();
    test_reset_vs_write();
    test_counter();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
